krz_sysbus: RTL and testbench

KRZ_SYSBUS -- requirements
Module: krz_sysbus

---
 rtl/krz_sysbus.sv | 147 ++++++++++++++
 tb/tb_krz_sysbus.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/krz_sysbus.sv
// rtl/krz_sysbus.sv - system-bus bridge with four 1MB slave slots, timeout and error counting
module krz_sysbus #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rstz,
   input  logic [23:0]  sys_adr_i,
   input  logic [31:0]  sys_dat_i,
   output logic [31:0]  sys_dat_o,
   input  logic         sys_we_i,
   input  logic [3:0]   sys_sel_i,
   input  logic         sys_stb_i,
   output logic         sys_ack_o,
   output logic [23:0]  s_adr_o,
   output logic [31:0]  s_dat_o,
   output logic         s_we_o,
   output logic [3:0]   s_sel_o,
   output logic [3:0]   s_stb_o,
   input  logic [127:0] s_dat_i,
   input  logic [3:0]   s_ack_i,
   output logic         err_o,
   output logic [7:0]   err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_HOLD
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [23:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [1:0]  slot_q, slot_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic [7:0]  cnt_inc;
   logic [6:0]  rd_base;
   logic [31:0] slot_rdata;

   assign cnt_inc    = cnt_q + 8'd1;
   assign rd_base    = {slot_q, 5'd0};
   assign slot_rdata = s_dat_i[rd_base +: 32];

   // Next-state and capture logic for the single outstanding transaction
   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      we_d      = we_q;
      sel_d     = sel_q;
      slot_d    = slot_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      err_cnt_d = err_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (sys_stb_i) begin
               adr_d  = sys_adr_i;
               dat_d  = sys_dat_i;
               we_d   = sys_we_i;
               sel_d  = sys_sel_i;
               slot_d = sys_adr_i[21:20];
               cnt_d  = 8'd0;
               err_d  = 1'b0;
               if (sys_adr_i[22]) begin
                  // Unmapped: complete immediately with an error and zero data
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            if (s_ack_i[slot_q]) begin
               rdata_d = slot_rdata;
               state_d = ST_ACK;
            end else if (cnt_inc == TIMEOUT_C) begin
               rdata_d = 32'd0;
               err_d   = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (err_q && (err_cnt_q != 8'hFF)) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            // Master strobe is still high here; it must not start a new request
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstz) begin
         state_q   <= ST_IDLE;
         adr_q     <= 24'd0;
         dat_q     <= 32'd0;
         we_q      <= 1'b0;
         sel_q     <= 4'd0;
         slot_q    <= 2'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         slot_q    <= slot_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign s_adr_o   = adr_q;
   assign s_dat_o   = dat_q;
   assign s_we_o    = we_q;
   assign s_sel_o   = sel_q;
   assign s_stb_o   = (state_q == ST_WAIT) ? (4'b0001 << slot_q) : 4'b0000;
   assign sys_ack_o = (state_q == ST_ACK);
   assign err_o     = (state_q == ST_ACK) && err_q;
   assign sys_dat_o = rdata_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_krz_sysbus.sv
// tb/tb_krz_sysbus.sv - self-checking bench for krz_sysbus
module tb_krz_sysbus;

   localparam int TMO = 4;

   logic         clk = 1'b0;
   logic         rstz;
   logic [23:0]  sys_adr_i;
   logic [31:0]  sys_dat_i;
   logic [31:0]  sys_dat_o;
   logic         sys_we_i;
   logic [3:0]   sys_sel_i;
   logic         sys_stb_i;
   logic         sys_ack_o;
   logic [23:0]  s_adr_o;
   logic [31:0]  s_dat_o;
   logic         s_we_o;
   logic [3:0]   s_sel_o;
   logic [3:0]   s_stb_o;
   logic [127:0] s_dat_i;
   logic [3:0]   s_ack_i;
   logic         err_o;
   logic [7:0]   err_cnt;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   krz_sysbus #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rstz(rstz),
      .sys_adr_i(sys_adr_i), .sys_dat_i(sys_dat_i), .sys_dat_o(sys_dat_o),
      .sys_we_i(sys_we_i), .sys_sel_i(sys_sel_i), .sys_stb_i(sys_stb_i),
      .sys_ack_o(sys_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .err_o(err_o), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: which request is pending, how long it has waited,
   // and what the master should see, advanced once per clock edge.
   bit          m_pending, m_ack_due, m_err, m_after_ack;
   int          m_slot, m_waited, m_errs;
   logic [31:0] m_rdata;
   logic [23:0] m_adr;
   logic [31:0] m_dat;
   logic        m_we;
   logic [3:0]  m_sel;

   always @(posedge clk) begin
      if (!rstz) begin
         m_pending = 0; m_ack_due = 0; m_err = 0; m_after_ack = 0;
         m_slot = 0; m_waited = 0; m_errs = 0; m_rdata = '0;
         m_adr = '0; m_dat = '0; m_we = 1'b0; m_sel = '0;
      end else if (m_ack_due) begin
         if (m_err) m_errs = (m_errs < 255) ? m_errs + 1 : 255;
         m_ack_due = 0; m_err = 0; m_after_ack = 1;
      end else if (m_after_ack) begin
         m_after_ack = 0;
      end else if (m_pending) begin
         m_waited = m_waited + 1;
         if (s_ack_i[m_slot]) begin
            m_rdata = s_dat_i[m_slot*32 +: 32];
            m_pending = 0; m_ack_due = 1;
         end else if (m_waited == TMO) begin
            m_rdata = '0; m_err = 1;
            m_pending = 0; m_ack_due = 1;
         end
      end else if (sys_stb_i) begin
         m_adr = sys_adr_i; m_dat = sys_dat_i; m_we = sys_we_i; m_sel = sys_sel_i;
         if (sys_adr_i[22]) begin
            m_rdata = '0; m_err = 1; m_ack_due = 1;
         end else begin
            m_slot = int'(sys_adr_i[21:20]); m_waited = 0; m_pending = 1;
         end
      end
   end

   // Every-cycle comparison of all outputs against the reference
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_stb", 32'(s_stb_o), m_pending ? 32'(1 << m_slot) : 32'd0);
         chk("m_ack", 32'(sys_ack_o), 32'(m_ack_due));
         chk("m_err", 32'(err_o), 32'(m_ack_due && m_err));
         chk("m_rdata", sys_dat_o, m_rdata);
         chk("m_errcnt", 32'(err_cnt), 32'(m_errs));
         chk("m_adr", 32'(s_adr_o), 32'(m_adr));
         chk("m_dat", s_dat_o, m_dat);
         chk("m_we", 32'(s_we_o), 32'(m_we));
         chk("m_sel", 32'(s_sel_o), 32'(m_sel));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic [23:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel);
      sys_adr_i = a; sys_dat_i = d; sys_we_i = we; sys_sel_i = sel; sys_stb_i = 1'b1;
   endtask

   initial begin
      rstz = 1'b0; sys_adr_i = '0; sys_dat_i = '0; sys_we_i = 1'b0; sys_sel_i = '0;
      sys_stb_i = 1'b0; s_dat_i = '0; s_ack_i = '0;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_dat", sys_dat_o, 32'd0);
      chk("rst_ack", 32'(sys_ack_o), 32'd0);
      chk("rst_stb", 32'(s_stb_o), 32'd0);
      chk("rst_errcnt", 32'(err_cnt), 32'd0);
      chk("rst_adr", 32'(s_adr_o), 32'd0);
      rstz = 1'b1;
      tick();

      // Read of slot 1 with minimum latency
      req(24'h912340, 32'h0, 1'b0, 4'hF);
      tick();
      chk("rd_stb", 32'(s_stb_o), 32'h2);
      s_ack_i = 4'b0010; s_dat_i[63:32] = 32'hCAFEF00D;
      tick();
      chk("rd_ack", 32'(sys_ack_o), 32'd1);
      chk("rd_dat_n2", sys_dat_o, 32'hCAFEF00D);
      chk("rd_stb_off", 32'(s_stb_o), 32'd0);
      s_ack_i = '0;
      tick();
      chk("rd_dat_n3", sys_dat_o, 32'hCAFEF00D);
      chk("rd_no_2nd_ack", 32'(sys_ack_o), 32'd0);
      sys_stb_i = 1'b0;
      tick();
      chk("rd_idle_ack", 32'(sys_ack_o), 32'd0);

      // Write to slot 3, master strobe dropped while waiting
      req(24'hB00004, 32'h12345678, 1'b1, 4'h3);
      tick();
      chk("wr_adr", 32'(s_adr_o), 32'hB00004);
      chk("wr_dat", s_dat_o, 32'h12345678);
      chk("wr_sel", 32'(s_sel_o), 32'h3);
      chk("wr_we", 32'(s_we_o), 32'd1);
      chk("wr_stb", 32'(s_stb_o), 32'h8);
      sys_stb_i = 1'b0;
      tick();
      chk("wr_stb2", 32'(s_stb_o), 32'h8);
      s_ack_i = 4'b1000; s_dat_i[127:96] = 32'hDEAD0003;
      tick();
      chk("wr_ack", 32'(sys_ack_o), 32'd1);
      s_ack_i = '0;
      tick(); tick();

      // Unmapped address
      req(24'hC00000, 32'h0, 1'b0, 4'hF);
      tick();
      chk("um_ack", 32'(sys_ack_o), 32'd1);
      chk("um_err", 32'(err_o), 32'd1);
      chk("um_dat", sys_dat_o, 32'd0);
      chk("um_stb", 32'(s_stb_o), 32'd0);
      sys_stb_i = 1'b0;
      tick();
      chk("um_errcnt", 32'(err_cnt), 32'd1);
      tick();

      // Timeout on slot 2
      req(24'h200000, 32'h0, 1'b0, 4'hF);
      tick();
      sys_stb_i = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         chk("to_stb", 32'(s_stb_o), 32'h4);
         chk("to_noack", 32'(sys_ack_o), 32'd0);
         tick();
      end
      chk("to_ack", 32'(sys_ack_o), 32'd1);
      chk("to_err", 32'(err_o), 32'd1);
      chk("to_dat", sys_dat_o, 32'd0);
      tick(); tick();
      chk("to_errcnt", 32'(err_cnt), 32'd2);

      // Stray acks from other slots while slot 2 is pending
      req(24'h2ABCDE, 32'h0, 1'b0, 4'hF);
      s_dat_i = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
      tick();
      sys_stb_i = 1'b0;
      s_ack_i = 4'b1011;
      tick();
      chk("stray_noack", 32'(sys_ack_o), 32'd0);
      tick();
      chk("stray_stb", 32'(s_stb_o), 32'h4);
      s_ack_i = 4'b1111;
      tick();
      chk("stray_ack", 32'(sys_ack_o), 32'd1);
      chk("stray_dat", sys_dat_o, 32'h22222222);
      chk("stray_err", 32'(err_o), 32'd0);
      s_ack_i = '0;
      tick(); tick();

      // Reset while waiting on slot 0, then a clean transaction
      req(24'h000010, 32'h0, 1'b0, 4'hF);
      tick();
      chk("rw_stb", 32'(s_stb_o), 32'h1);
      rstz = 1'b0; sys_stb_i = 1'b0;
      tick();
      chk("rw_stb_off", 32'(s_stb_o), 32'd0);
      chk("rw_noack", 32'(sys_ack_o), 32'd0);
      chk("rw_errcnt", 32'(err_cnt), 32'd0);
      rstz = 1'b1;
      tick();
      chk("rw_noack2", 32'(sys_ack_o), 32'd0);
      req(24'h0000F0, 32'h0, 1'b0, 4'hF);
      tick();
      sys_stb_i = 1'b0;
      s_ack_i = 4'b0001; s_dat_i[31:0] = 32'h0A0A0A0A;
      tick();
      chk("rw_ack", 32'(sys_ack_o), 32'd1);
      chk("rw_dat", sys_dat_o, 32'h0A0A0A0A);
      s_ack_i = '0;
      tick(); tick();

      // Error counter saturation
      for (int i = 0; i < 256; i++) begin
         req(24'hC00000, 32'h0, 1'b0, 4'hF);
         tick();
         sys_stb_i = 1'b0;
         tick(); tick();
      end
      chk("sat_errcnt", 32'(err_cnt), 32'd255);
      req(24'hC00000, 32'h0, 1'b0, 4'hF);
      tick();
      chk("sat_err_pulse", 32'(err_o), 32'd1);
      sys_stb_i = 1'b0;
      tick(); tick();
      chk("sat_hold", 32'(err_cnt), 32'd255);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
